// File: rtl/persist_integrator_pkg.sv
// Shared definitions for the persist integrator.
// Holds the state encodings, the default accumulator width and the saturation limits
// for the default 16-bit output.
package persist_integrator_pkg;

  // Window state encodings
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam int unsigned ACC_WIDTH_DEFAULT = 32;
  localparam int unsigned OUT_WIDTH_DEFAULT = 16;

  // Saturation limits for the default output width
  localparam logic signed [ACC_WIDTH_DEFAULT-1:0] SAT_MAX_DEFAULT = 32'sd32767;
  localparam logic signed [ACC_WIDTH_DEFAULT-1:0] SAT_MIN_DEFAULT = -32'sd32768;

endpackage

// File: rtl/persist_integrator_sat_shift.sv
// Combinational post-processing of a window sum.
// Arithmetic right shift (floor toward -inf), then clamp to the signed OUT_DATA_WIDTH range.
// Optional ReLU after saturation when PERSIST_INTEGRATOR_RELU_EN is defined.
//
// Ports:
//   sum    - signed window sum, ACC_WIDTH bits
//   shift  - arithmetic right-shift amount
//   result - saturated (optionally rectified) result, OUT_DATA_WIDTH bits
module persist_integrator_sat_shift
  import persist_integrator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEFAULT,
  parameter int unsigned OUT_DATA_WIDTH = OUT_WIDTH_DEFAULT
) (
  input  logic signed [ACC_WIDTH-1:0]      sum,
  input  logic        [4:0]                shift,
  output logic signed [OUT_DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] SatMax =
      ACC_WIDTH'((longint'(1) <<< (OUT_DATA_WIDTH - 1)) - longint'(1));
  // Two's complement: -(max) - 1 == ~max
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;

  logic signed [ACC_WIDTH-1:0]      shifted;
  logic signed [OUT_DATA_WIDTH-1:0] sat;

  always_comb begin
    // >>> on a signed operand rounds toward -inf
    shifted = sum >>> shift;
    if (shifted > SatMax) begin
      sat = SatMax[OUT_DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      sat = SatMin[OUT_DATA_WIDTH-1:0];
    end else begin
      sat = shifted[OUT_DATA_WIDTH-1:0];
    end
  end

`ifdef PERSIST_INTEGRATOR_RELU_EN
  assign result = sat[OUT_DATA_WIDTH-1] ? '0 : sat;
`else
  assign result = sat;
`endif

endmodule

// File: rtl/persist_integrator.sv
// Persist-window integrator.
// Sums persist_cycle_length valid beats of the averaged sample stream, scales the sum by
// 2^-avg_shift (floor), saturates, and emits one result per window through a one-entry
// valid/ready output register.
// Optional macro PERSIST_INTEGRATOR_RELU_EN: clamp negative results to zero.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start_signal         - one-cycle pulse, arms/restarts a window
//   persist_cycle_length - beats per window, sampled on start_signal
//   avg_shift            - right-shift amount, sampled on start_signal
//   s_tdata, s_tvalid    - input samples (no backpressure)
//   m_tdata, m_tvalid    - window result
//   m_tready             - consumer accepts result
//   busy                 - high while accumulating
//   overflow             - sticky: an unconsumed result was overwritten
module persist_integrator
  import persist_integrator_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 16,
  parameter int unsigned OUT_DATA_WIDTH = OUT_WIDTH_DEFAULT,
  parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_signal,
  input  logic        [15:0]               persist_cycle_length,
  input  logic        [4:0]                avg_shift,
  input  logic signed [IN_DATA_WIDTH-1:0]  s_tdata,
  input  logic                             s_tvalid,
  output logic signed [OUT_DATA_WIDTH-1:0] m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             busy,
  output logic                             overflow
);

  logic        [0:0]                state_q, state_d;
  logic signed [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic        [15:0]               count_q, count_d;
  logic        [15:0]               len_q, len_d;
  logic        [4:0]                shift_q, shift_d;
  logic signed [OUT_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                             m_tvalid_q, m_tvalid_d;
  logic                             overflow_q, overflow_d;

  logic signed [ACC_WIDTH-1:0]      sample_ext;
  logic signed [ACC_WIDTH-1:0]      sum;
  logic signed [OUT_DATA_WIDTH-1:0] result;
  logic                             beat;
  logic                             last_beat;

  assign sample_ext = {{(ACC_WIDTH - IN_DATA_WIDTH){s_tdata[IN_DATA_WIDTH-1]}}, s_tdata};
  assign sum        = acc_q + sample_ext;
  assign beat       = (state_q == ACCUM) && s_tvalid;
  // A start on the last beat wins, so that beat never completes the window
  assign last_beat  = beat && !start_signal && (count_q == len_q - 16'd1);

  persist_integrator_sat_shift #(
    .ACC_WIDTH      (ACC_WIDTH),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_sat_shift (
    .sum    (sum),
    .shift  (shift_q),
    .result (result)
  );

  // Window control
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    len_d      = len_q;
    shift_d    = shift_q;
    if (start_signal) begin
      len_d   = persist_cycle_length;
      shift_d = avg_shift;
      acc_d   = '0;
      count_d = '0;
      state_d = (persist_cycle_length != 16'd0) ? ACCUM : IDLE;
    end else if (last_beat) begin
      acc_d   = '0;
      count_d = '0;
      state_d = IDLE;
    end else if (beat) begin
      acc_d   = sum;
      count_d = count_q + 16'd1;
    end
  end

  // Output register and overflow tracking
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    overflow_d = overflow_q;
    if (start_signal) begin
      overflow_d = 1'b0;
    end
    if (last_beat) begin
      m_tdata_d  = result;
      m_tvalid_d = 1'b1;
      // Only an unconsumed result counts as lost; a same-cycle transfer is fine
      if (m_tvalid_q && !m_tready) begin
        overflow_d = 1'b1;
      end
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == ACCUM);

endmodule

// File: tb/tb_persist_integrator.sv
module tb_persist_integrator;

`ifdef PERSIST_INTEGRATOR_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_signal = 1'b0;
  logic        [15:0] persist_cycle_length = '0;
  logic        [4:0]  avg_shift = '0;
  logic signed [15:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               m_tready = 1'b1;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic               busy;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  persist_integrator dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_signal         (start_signal),
    .persist_cycle_length (persist_cycle_length),
    .avg_shift            (avg_shift),
    .s_tdata              (s_tdata),
    .s_tvalid             (s_tvalid),
    .m_tdata              (m_tdata),
    .m_tvalid             (m_tvalid),
    .m_tready             (m_tready),
    .busy                 (busy),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Window described as "beats remaining" plus a running integer sum.
  logic   mod_act;
  int     mod_rem;
  longint mod_sum;
  int     mod_shift;
  logic   exp_valid;
  logic   exp_ovf;
  int     exp_data;
  logic   mod_last;

  function automatic int model_result(longint s, int sh);
    longint d;
    longint q;
    d = longint'(1) << sh;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);   // floor toward -inf
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    if (Relu && q < 0) q = 0;
    return int'(q);
  endfunction

  assign mod_last = !start_signal && mod_act && s_tvalid && (mod_rem == 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_act   <= 1'b0;
      mod_rem   <= 0;
      mod_sum   <= 0;
      mod_shift <= 0;
      exp_valid <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_data  <= 0;
    end else begin
      if (start_signal) begin
        mod_act   <= (persist_cycle_length != 16'd0);
        mod_rem   <= int'(persist_cycle_length);
        mod_sum   <= 0;
        mod_shift <= int'(avg_shift);
        exp_ovf   <= 1'b0;
      end else if (mod_act && s_tvalid) begin
        if (mod_last) mod_act <= 1'b0;
        mod_rem <= mod_rem - 1;
        mod_sum <= mod_sum + longint'(s_tdata);
      end
      if (mod_last) begin
        exp_valid <= 1'b1;
        exp_data  <= model_result(mod_sum + longint'(s_tdata), mod_shift);
        if (exp_valid && !m_tready) exp_ovf <= 1'b1;
      end else if (exp_valid && m_tready) begin
        exp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("model m_tvalid", int'(m_tvalid), int'(exp_valid));
      chk("model busy", int'(busy), int'(mod_act));
      chk("model overflow", int'(overflow), int'(exp_ovf));
      chk("model m_tdata", int'(m_tdata), exp_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int sh);
    start_signal         = 1'b1;
    persist_cycle_length = 16'(len);
    avg_shift            = 5'(sh);
    step();
    start_signal = 1'b0;
  endtask

  task automatic beat(input int val);
    s_tvalid = 1'b1;
    s_tdata  = 16'(val);
    step();
    s_tvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("reset m_tvalid", int'(m_tvalid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset m_tdata", int'(m_tdata), 0);
    rst = 1'b0;
    step();

    // Basic window: (100+200+300+400)>>2 = 250
    m_tready = 1'b1;
    do_start(4, 2);
    chk("basic busy", int'(busy), 1);
    beat(100);
    beat(200);
    beat(300);
    chk("basic no early valid", int'(m_tvalid), 0);
    beat(400);
    chk("basic valid", int'(m_tvalid), 1);
    chk("basic data", int'(m_tdata), 250);
    chk("basic busy done", int'(busy), 0);
    step();
    chk("basic single pulse", int'(m_tvalid), 0);

    // Negative saturation and floor
    do_start(2, 0);
    beat(-32768);
    beat(-32768);
    chk("sat data", int'(m_tdata), Relu ? 0 : -32768);
    step();
    do_start(1, 1);
    beat(-3);
    chk("floor data", int'(m_tdata), Relu ? 0 : -2);
    step();

    // Backpressure and overflow
    m_tready = 1'b0;
    do_start(1, 0);
    beat(5);
    chk("bp first data", int'(m_tdata), 5);
    do_start(1, 0);
    chk("bp data held", int'(m_tdata), 5);
    beat(7);
    chk("bp overwrite data", int'(m_tdata), 7);
    chk("bp overflow", int'(overflow), 1);
    m_tready = 1'b1;
    step();
    chk("bp valid drop", int'(m_tvalid), 0);
    chk("bp overflow sticky", int'(overflow), 1);
    do_start(4, 0);
    chk("bp overflow cleared", int'(overflow), 0);

    // Gapped input then restart
    do_start(3, 0);
    beat(1);
    step();
    beat(2);
    step();
    do_start(3, 0);
    chk("restart no output", int'(m_tvalid), 0);
    beat(10);
    step();
    beat(10);
    beat(10);
    chk("restart data", int'(m_tdata), 30);
    step();

    // Length zero, IDLE beats ignored
    do_start(0, 0);
    chk("len0 busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) beat(1000);
    chk("len0 no valid", int'(m_tvalid), 0);
    do_start(1, 0);
    beat(1);
    chk("after idle beats data", int'(m_tdata), 1);
    step();

    // Async reset mid-window with a pending result
    m_tready = 1'b0;
    do_start(1, 0);
    beat(77);
    do_start(3, 0);
    beat(9);
    chk("pre-reset busy", int'(busy), 1);
    chk("pre-reset valid", int'(m_tvalid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async valid", int'(m_tvalid), 0);
    chk("async data", int'(m_tdata), 0);
    chk("async busy", int'(busy), 0);
    chk("async overflow", int'(overflow), 0);
    step();
    step();
    rst = 1'b0;
    m_tready = 1'b1;
    step();
    do_start(2, 0);
    beat(1);
    beat(1);
    chk("post-reset data", int'(m_tdata), 2);
    chk("post-reset valid", int'(m_tvalid), 1);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/persist_integrator.md
Name: persist_integrator

Overview:
- Downstream stage of the 16-bit averager tree in the digital compute datapath.
- Integrates the averaged sample stream over one persist window of `persist_cycle_length` valid beats.
- Scales the sum by a programmable power of two, saturates it, and emits one 16-bit result per window through a one-entry valid/ready output register.
- Feeds the nonlinearity / readout stage.

Parameters:
- IN_DATA_WIDTH, 16, width of signed input sample.
- OUT_DATA_WIDTH, 16, width of signed output result.
- ACC_WIDTH, 32, accumulator width; must be >= IN_DATA_WIDTH+16.

Ports:
- clk  in  1  datapath clock.
- rst  in  1  asynchronous active-high reset.
- start_signal  in  1  one-cycle pulse; arms a new window.
- persist_cycle_length  in  16  beats per window; sampled on start_signal.
- avg_shift  in  5  arithmetic right-shift amount applied to the sum; sampled on start_signal.
- s_tdata  in  IN_DATA_WIDTH  signed averaged sample.
- s_tvalid  in  1  sample qualifier; no backpressure upstream.
- m_tdata  out  OUT_DATA_WIDTH  signed window result.
- m_tvalid  out  1  result valid.
- m_tready  in  1  consumer accepts result.
- busy  out  1  high while in ACCUM.
- overflow  out  1  sticky: an unconsumed result was overwritten.

Behaviour:
- Reset: one clock domain, `clk`; `rst` is asynchronous, active-high.
  - Reset values: state=IDLE, acc=0, count=0, m_tdata=0, m_tvalid=0, busy=0, overflow=0.
- States: IDLE, ACCUM.
- IDLE:
  - s_tvalid beats are ignored.
  - On start_signal: latch length and shift, clear acc/count, clear overflow.
  - Go to ACCUM if latched length != 0; otherwise stay in IDLE and emit nothing.
- ACCUM:
  - Each s_tvalid beat: acc += sign_extend(s_tdata); count += 1.
  - Beat where count == length-1 (the last beat):
    - result = saturate((acc + sample) >>> shift), floor rounding toward -inf.
    - Result is loaded into the output register; state returns to IDLE.
  - Beats with s_tvalid=0 do not advance.
- start_signal in ACCUM: restarts the window (re-latch length/shift, clear acc/count, clear overflow). The output register is untouched.
- start_signal coinciding with the last beat: start wins; the partial window is discarded.
- Latency: m_tvalid rises on the cycle after the last beat.
- Saturation: clamp to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1]. The accumulator cannot wrap at the default widths.
- Output handshake:
  - Transfer occurs when m_tvalid && m_tready.
  - m_tdata holds stable while m_tvalid && !m_tready.
  - m_tvalid clears on transfer unless a new result loads in the same cycle; then m_tvalid stays 1 with the new data and overflow is not set.
  - New result while m_tvalid && !m_tready: overwrite the old result; set overflow (sticky until next start or reset).
- busy = (state == ACCUM).

Optional Feature:
- Macro: PERSIST_INTEGRATOR_RELU_EN.
- Defined: after saturation, negative results are replaced by 0 (ReLU). The overflow/handshake path is unchanged.
- Undefined: the signed saturated result passes through unchanged.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=1'b0, ACCUM=1'b1;
  - ACC_WIDTH default;
  - saturation limit constants.
- One natural combinational sub-module: sat_shift (arithmetic shift by avg_shift, then saturate ACC_WIDTH -> OUT_DATA_WIDTH, optional ReLU). Instantiated once.

Test Plan:
- Basic window: start with length=4, shift=2; send 100, 200, 300, 400 (m_tready=1) -> exactly one m_tvalid pulse, m_tdata=250, one cycle after the 4th beat; busy high for the window.
- Negative floor and saturation:
  - length=2, shift=0, samples -32768, -32768 -> m_tdata=-32768 (saturated).
  - length=1, shift=1, sample -3 -> m_tdata=-2.
  - With the macro defined, both results are 0.
- Backpressure and overflow:
  - m_tready=0; two windows: length=1 sample 5, then length=1 sample 7 -> m_tdata=7, overflow=1.
  - Raise m_tready -> one transfer, m_tvalid drops.
  - Next start clears overflow.
- Gapped input and restart:
  - length=3 with s_tvalid gaps, 2 beats sent, then start_signal -> no output.
  - New window of 3 beats of 10, shift=0 -> m_tdata=30.
- Length zero and IDLE beats: start with length=0, then 8 s_tvalid beats -> busy stays 0, m_tvalid stays 0, acc unaffected.
- Async reset mid-ACCUM: assert rst between clock edges -> all outputs 0 immediately.
  - After release, a start with length=2, samples 1, 1 -> m_tdata=2.
